// File: rtl/mux_tree_pkg.sv
// Shared definitions for the 8-leg mux tree arbiter: FSM state encoding,
// tree geometry and which select bit steers which tree layer.
package mux_tree_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ARB   = 2'd1;
    localparam state_t ST_GRANT = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Select bit index driving each tree layer (layer 4 is the final 2:1 stage)
    localparam int SEL_BIT_LAYER2 = 0;
    localparam int SEL_BIT_LAYER3 = 1;
    localparam int SEL_BIT_LAYER4 = 2;

endpackage

// File: rtl/mux_tree_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set request at or above ptr
// (wrapping) in round-robin mode, lowest set request in fixed-priority mode.
module rr_pick
    import mux_tree_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // Walk the legs starting at ptr; the 3-bit add gives the 7->0 wrap for free
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = mode ? SEL_W'(k) : ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_tree_arbiter.sv
// Arbiter and sequencer for the 8-leg mux tree: picks an owner, drives the
// registered tree selects and bounds each owner's tenure to HOLD_MAX cycles.
module mux_tree_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    input  logic             cfg_mode,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);
    import mux_tree_pkg::*;

    localparam logic [3:0]       HOLD_LAST = 4'(HOLD_MAX - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [3:0]       hold_cnt;
    logic [SEL_W-1:0] pick_win;
    logic             pick_any;
    logic             grant_end;

    rr_pick u_rr_pick (
        .req  (req),
        .ptr  (ptr),
        .mode (cfg_mode),
        .win  (pick_win),
        .any  (pick_any)
    );

    assign grant_end = done || !req[sel] || (hold_cnt == HOLD_LAST);
    assign busy      = (state != ST_IDLE);

    // gnt/sel are only rewritten in ARB so the tree path stays stable through DRAIN and IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            sel       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req)
                        state <= ST_ARB;
                end
                ST_ARB: begin
                    if (pick_any) begin
                        gnt       <= ONE_HOT0 << pick_win;
                        sel       <= pick_win;
                        hold_cnt  <= '0;
                        gnt_valid <= 1'b1;
                        state     <= ST_GRANT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != HOLD_LAST)
                        hold_cnt <= hold_cnt + 4'd1;
                    if (grant_end) begin
                        gnt_valid <= 1'b0;
                        state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Mode is looked at live so a switch to round-robin during a fixed-priority tenure moves past the owner
                    if (!cfg_mode)
                        ptr <= sel + SEL_W'(1);
                    state <= (|req) ? ST_ARB : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
